// File: rtl/input_conditioner_pkg.sv
// input_cond_pkg: shared debounce state type, counter sizing and 50 MHz timing defaults
package input_cond_pkg;
   typedef enum logic {STABLE, CHANGING} db_state_e;
   localparam int DEF_DEBOUNCE_CYCLES = 500_000;
   localparam int DEF_REPEAT_DELAY = 25_000_000;
   localparam int DEF_REPEAT_PERIOD = 5_000_000;
   function automatic int cnt_width(input int cycles);
      return $clog2(cycles + 1);
   endfunction
endpackage

// File: rtl/input_conditioner_if.sv
// input_conditioner_if: raw pin inputs and conditioned button/switch outputs
interface input_conditioner_if #(parameter int N_BTN = 4, parameter int N_SW = 2);
   logic [N_BTN-1:0] btn_raw, btn_level, btn_press, btn_release;
   logic [N_SW-1:0] sw_raw, sw_level;
   modport master (output btn_raw, sw_raw, input btn_level, btn_press, btn_release, sw_level);
   modport slave (input btn_raw, sw_raw, output btn_level, btn_press, btn_release, sw_level);
endinterface

// File: rtl/input_conditioner_debounce_bit.sv
// debounce_bit: two-flop sync, STABLE/CHANGING debounce FSM and registered edge strobes for one input
module debounce_bit
   import input_cond_pkg::*;
#(
   parameter bit INVERT = 1'b0,
   parameter int CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall
);
   localparam int CW = cnt_width(CYCLES);
   db_state_e state, state_nx;
   logic [1:0] sync;
   logic [CW-1:0] cnt, cnt_nx;
   logic s, diff, done;
   assign s = sync[1] ^ INVERT;
   assign diff = s != level;
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= STABLE;
      else state <= state_nx;
   always_comb state_nx = diff && !done ? CHANGING : STABLE;
   always_comb begin
      done = state == CHANGING && diff && cnt == CW'(CYCLES - 1);
      cnt_nx = diff && !done ? cnt + 1'b1 : '0;
   end
   // sync flops idle at the inactive raw level so reset never fakes an edge
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sync <= {2{INVERT}};
         cnt <= '0;
         level <= 1'b0;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         sync <= {sync[0], raw};
         cnt <= cnt_nx;
         level <= done ? s : level;
         rise <= done & s;
         fall <= done & ~s;
      end
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: synchronise and debounce board buttons and switches, emit press/release strobes
// Optional auto-repeat of btn_press while held: define INPUT_COND_AUTOREPEAT_EN.
module input_conditioner
   import input_cond_pkg::*;
#(
   parameter int N_BTN = 4,
   parameter int N_SW = 2,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter bit BTN_ACTIVE_LOW = 1'b1,
   parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
   input  logic clk_clk,
   input  logic reset_reset,
   input_conditioner_if.slave io
);
   logic [N_BTN-1:0] level, rise, fall;
   logic [N_SW-1:0] sw_lvl, sw_rise_unused, sw_fall_unused;
   if (DEBOUNCE_CYCLES < 2 || REPEAT_PERIOD < 1 || REPEAT_DELAY < REPEAT_PERIOD) begin : g_bad_cfg
      $error("input_conditioner: illegal timing parameters");
   end
   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      debounce_bit #(.INVERT(BTN_ACTIVE_LOW), .CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk(clk_clk), .rst(reset_reset), .raw(io.btn_raw[i]),
         .level(level[i]), .rise(rise[i]), .fall(fall[i]));
   end
   for (genvar i = 0; i < N_SW; i++) begin : g_sw
      debounce_bit #(.INVERT(1'b0), .CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk(clk_clk), .rst(reset_reset), .raw(io.sw_raw[i]),
         .level(sw_lvl[i]), .rise(sw_rise_unused[i]), .fall(sw_fall_unused[i]));
   end
   assign io.btn_level = level;
   assign io.btn_release = fall;
   assign io.sw_level = sw_lvl;
`ifdef INPUT_COND_AUTOREPEAT_EN
   localparam int HW = cnt_width(REPEAT_DELAY);
   logic [N_BTN-1:0][HW-1:0] hold;
   logic [N_BTN-1:0] rep;
   // after the first repeat the counter reloads so later ticks land every REPEAT_PERIOD
   always_ff @(posedge clk_clk or posedge reset_reset)
      if (reset_reset) begin
         hold <= '0;
         rep <= '0;
      end else begin
         for (int b = 0; b < N_BTN; b++) begin
            hold[b] <= !level[b] ? '0 : hold[b] == HW'(REPEAT_DELAY - 1) ? HW'(REPEAT_DELAY - REPEAT_PERIOD) : hold[b] + 1'b1;
            rep[b] <= level[b] && hold[b] == HW'(REPEAT_DELAY - 1);
         end
      end
   assign io.btn_press = rise | (rep & level);
`else
   assign io.btn_press = rise;
`endif
endmodule
